vending_controller: RTL

- Parametrised vending FSM for a single product at a configurable price. Accepts nickel, dime and quarter coin pulses and accumulates credit in 5-cent units.
- Issues a one-cycle deliver pulse once credit reaches PRICE.
- Returns change or a cancel refund serially, one coin per valid/ready handshake, using greedy coin selection. The coin-return actuator sits downstream of this handshake.

---
 rtl/vending_controller.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/vending_controller.sv
// Single-product vending controller.
// Credit is counted in 5-cent units. A purchase is released with a one-cycle
// deliver pulse. Any change or cancel refund is paid back one coin per
// valid/ready handshake, largest coin first.
module vending_controller #(
  parameter int PRICE      = 5,
  parameter int MAX_CREDIT = 9,
  parameter int CW         = $clog2(MAX_CREDIT+1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          nickel,
  input  logic          dime,
  input  logic          quarter,
  input  logic          cancel,
  input  logic          change_ready,
  output logic          deliver,
  output logic          change_valid,
  output logic [1:0]    change_coin,
  output logic          coin_reject,
  output logic [CW-1:0] credit,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    VEND   = 2'd1,
    CHANGE = 2'd2
  } state_t;

  // Arithmetic is done a few bits wider than the credit register, so that
  // credit + quarter cannot wrap before it is compared against MAX_CREDIT.
  localparam int SW = CW + 3;
  typedef logic [SW-1:0] wide_t;

  localparam wide_t PRICE_W = wide_t'(PRICE);
  localparam wide_t MAX_W   = wide_t'(MAX_CREDIT);
  localparam wide_t NICKEL  = wide_t'(1);
  localparam wide_t DIME    = wide_t'(2);
  localparam wide_t QUARTER = wide_t'(5);

  localparam logic [1:0] CODE_NONE    = 2'b00;
  localparam logic [1:0] CODE_NICKEL  = 2'b01;
  localparam logic [1:0] CODE_DIME    = 2'b10;
  localparam logic [1:0] CODE_QUARTER = 2'b11;

  state_t        state, state_nxt;
  logic [CW-1:0] credit_nxt;

  wide_t         credit_w;
  wide_t         coin_val;
  wide_t         sum_w;
  wide_t         vend_rem_w;
  wide_t         chg_val;
  wide_t         chg_rem_w;
  logic [1:0]    chg_code;
  logic          any_coin;
  logic          multi_coin;
  logic          fits;
  logic          cancel_go;

  assign credit_w   = wide_t'(credit);
  assign any_coin   = nickel | dime | quarter;
  assign multi_coin = (nickel & dime) | (nickel & quarter) | (dime & quarter);

  // Value of the single coin considered this cycle: nickel > dime > quarter.
  always_comb begin
    coin_val = '0;
    if (nickel)       coin_val = NICKEL;
    else if (dime)    coin_val = DIME;
    else if (quarter) coin_val = QUARTER;
  end

  assign sum_w = credit_w + coin_val;
  assign fits  = (sum_w <= MAX_W);

  // A cancel with nothing inserted is meaningless, so it only counts with credit.
  assign cancel_go = cancel && (credit != '0);

  // Remainder after a sale; clamped so that a corrupted credit value cannot wrap.
  assign vend_rem_w = (credit_w >= PRICE_W) ? (credit_w - PRICE_W) : '0;

  // Greedy change selection: the largest coin that still fits the credit.
  always_comb begin
    chg_val  = NICKEL;
    chg_code = CODE_NICKEL;
    if (credit_w >= QUARTER) begin
      chg_val  = QUARTER;
      chg_code = CODE_QUARTER;
    end else if (credit_w >= DIME) begin
      chg_val  = DIME;
      chg_code = CODE_DIME;
    end
  end

  assign chg_rem_w = (credit_w >= chg_val) ? (credit_w - chg_val) : '0;

  // State and credit registers; reset forfeits any outstanding change.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      credit <= '0;
    end else begin
      state  <= state_nxt;
      credit <= credit_nxt;
    end
  end

  // Next-state and next-credit selection.
  always_comb begin
    state_nxt  = state;
    credit_nxt = credit;
    case (state)
      IDLE: begin
        if (cancel_go) begin
          state_nxt = CHANGE;
        end else if (any_coin && fits) begin
          credit_nxt = CW'(sum_w);
          if (sum_w >= PRICE_W) state_nxt = VEND;
        end
      end
      VEND: begin
        credit_nxt = CW'(vend_rem_w);
        state_nxt  = (vend_rem_w != '0) ? CHANGE : IDLE;
      end
      CHANGE: begin
        // Nothing left to return (only reachable through corruption): leave at once.
        if (credit == '0) begin
          state_nxt = IDLE;
        end else if (change_ready) begin
          credit_nxt = CW'(chg_rem_w);
          if (chg_rem_w == '0) state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt  = IDLE;
        credit_nxt = '0;
      end
    endcase
  end

  // Moore outputs from the registered state; coin_reject looks at this cycle's coins.
  always_comb begin
    deliver      = 1'b0;
    busy         = 1'b0;
    change_valid = 1'b0;
    change_coin  = CODE_NONE;
    coin_reject  = any_coin;
    case (state)
      IDLE: begin
        if (cancel_go) coin_reject = any_coin;
        else           coin_reject = any_coin && (!fits || multi_coin);
      end
      VEND: begin
        deliver = 1'b1;
        busy    = 1'b1;
      end
      CHANGE: begin
        busy         = 1'b1;
        change_valid = 1'b1;
        change_coin  = chg_code;
      end
      default: begin
        coin_reject = any_coin;
      end
    endcase
  end

endmodule
